// File: rtl/cnn_core_mul_arbiter_if.sv
// Requester/result bundle for cnn_core_mul_arbiter: per-requester operand handshakes plus
// the tagged product stream. req_lock exists only when CNN_MUL_ARB_LOCK_EN is defined.
interface cnn_core_mul_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int A_W     = 12,
    parameter int B_W     = 7,
    parameter int P_W     = 19,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*A_W-1:0] req_a;
    logic [NUM_REQ*B_W-1:0] req_b;
`ifdef CNN_MUL_ARB_LOCK_EN
    logic [NUM_REQ-1:0]     req_lock;
`endif
    logic                   res_valid;
    logic                   res_ready;
    logic [P_W-1:0]         res_data;
    logic [ID_W-1:0]        res_id;
    logic                   busy;

    modport master (
        input  req_ready, res_valid, res_data, res_id, busy,
`ifdef CNN_MUL_ARB_LOCK_EN
        output req_lock,
`endif
        output req_valid, req_a, req_b, res_ready
    );

    modport slave (
        output req_ready, res_valid, res_data, res_id, busy,
`ifdef CNN_MUL_ARB_LOCK_EN
        input  req_lock,
`endif
        input  req_valid, req_a, req_b, res_ready
    );
endinterface

// File: rtl/cnn_core_mul_arbiter.sv
// Round-robin arbiter sharing one signed A_W x B_W multiplier over a 2-stage pipeline.
// Define CNN_MUL_ARB_LOCK_EN to add req_lock, which keeps the grant on one requester.
module cnn_core_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int A_W     = 12,
    parameter int B_W     = 7,
    parameter int P_W     = 19,
    parameter int ID_W    = 2
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    cnn_core_mul_arbiter_if.slave  s_if
);

    localparam int            MIN_ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ID_W:0] NREQ_W   = (ID_W+1)'(NUM_REQ);

    if (P_W != A_W + B_W) begin : g_bad_pw
        $error("cnn_core_mul_arbiter: P_W must equal A_W+B_W");
    end
    if (ID_W < MIN_ID_W) begin : g_bad_idw
        $error("cnn_core_mul_arbiter: ID_W too narrow for NUM_REQ");
    end
    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_nreq
        $error("cnn_core_mul_arbiter: NUM_REQ must be 2..16");
    end

    logic                   r_v1, r_v2;
    logic signed [A_W-1:0]  r_a;
    logic signed [B_W-1:0]  r_b;
    logic [ID_W-1:0]        r_id1, r_id2;
    logic signed [P_W-1:0]  r_p;
    logic [ID_W-1:0]        r_ptr;

    logic                   w_en;
    logic                   w_accept;
    logic                   w_found;
    logic [ID_W-1:0]        w_win;
    logic [NUM_REQ-1:0]     w_elig;
    logic [NUM_REQ-1:0]     w_ready;
    logic [A_W-1:0]         w_a_arr [NUM_REQ];
    logic [B_W-1:0]         w_b_arr [NUM_REQ];
    logic signed [P_W-1:0]  w_prod;

    function automatic logic [ID_W-1:0] f_inc(input logic [ID_W-1:0] x);
        return (x == ID_W'(NUM_REQ-1)) ? '0 : x + 1'b1;
    endfunction

    // The whole pipeline moves only when the output slot is free or being drained.
    assign w_en = !r_v2 || s_if.res_ready;

`ifdef CNN_MUL_ARB_LOCK_EN
    logic            r_lock_act;
    logic [ID_W-1:0] r_lock_id;

    assign w_elig = r_lock_act ? (s_if.req_valid & (NUM_REQ'(1) << r_lock_id)) : s_if.req_valid;
`else
    assign w_elig = s_if.req_valid;
`endif

    // Scan offsets high to low so the lowest offset from the pointer is the last to win.
    always_comb begin
        logic [ID_W:0] v_idx;
        v_idx   = '0;
        w_found = 1'b0;
        w_win   = r_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            v_idx = {1'b0, r_ptr} + (ID_W+1)'(k);
            if (v_idx >= NREQ_W) begin
                v_idx = v_idx - NREQ_W;
            end
            if (w_elig[v_idx[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = v_idx[ID_W-1:0];
            end
        end
    end

    assign w_accept = w_en && w_found;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign w_ready[gi] = w_accept && (w_win == ID_W'(gi));
        assign w_a_arr[gi] = s_if.req_a[gi*A_W +: A_W];
        assign w_b_arr[gi] = s_if.req_b[gi*B_W +: B_W];
    end

    assign w_prod = $signed({{B_W{r_a[A_W-1]}}, r_a}) * $signed({{A_W{r_b[B_W-1]}}, r_b});

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_v1  <= 1'b0;
            r_v2  <= 1'b0;
            r_a   <= '0;
            r_b   <= '0;
            r_id1 <= '0;
            r_id2 <= '0;
            r_p   <= '0;
        end else if (w_en) begin
            r_v1 <= w_accept;
            if (w_accept) begin
                r_a   <= w_a_arr[w_win];
                r_b   <= w_b_arr[w_win];
                r_id1 <= w_win;
            end
            r_p   <= w_prod;
            r_id2 <= r_id1;
            r_v2  <= r_v1;
        end
    end

`ifdef CNN_MUL_ARB_LOCK_EN
    // A locked burst freezes the pointer; the closing beat hands the turn to lock_id+1.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_ptr      <= '0;
            r_lock_act <= 1'b0;
            r_lock_id  <= '0;
        end else if (w_accept) begin
            if (r_lock_act) begin
                if (!s_if.req_lock[w_win]) begin
                    r_lock_act <= 1'b0;
                    r_ptr      <= f_inc(r_lock_id);
                end
            end else begin
                r_ptr <= f_inc(w_win);
                if (s_if.req_lock[w_win]) begin
                    r_lock_act <= 1'b1;
                    r_lock_id  <= w_win;
                end
            end
        end
    end
`else
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= f_inc(w_win);
        end
    end
`endif

    assign s_if.req_ready = w_ready;
    assign s_if.res_valid = r_v2;
    assign s_if.res_data  = r_p;
    assign s_if.res_id    = r_id2;
    assign s_if.busy      = r_v1 || r_v2;

endmodule

// File: tb/tb_cnn_core_mul_arbiter.sv
// Directed bench for cnn_core_mul_arbiter: stimulus pushes hand-computed results into a
// queue and an independent monitor pops and compares each accepted output beat.
module tb_cnn_core_mul_arbiter;

    localparam int NUM_REQ = 4;
    localparam int A_W     = 12;
    localparam int B_W     = 7;
    localparam int P_W     = 19;
    localparam int ID_W    = 2;

    logic ap_clk = 1'b0;
    logic ap_rst_n;

    always #5 ap_clk = ~ap_clk;

    cnn_core_mul_arbiter_if #(
        .NUM_REQ(NUM_REQ), .A_W(A_W), .B_W(B_W), .P_W(P_W), .ID_W(ID_W)
    ) m_if ();

    cnn_core_mul_arbiter #(
        .NUM_REQ(NUM_REQ), .A_W(A_W), .B_W(B_W), .P_W(P_W), .ID_W(ID_W)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .s_if     (m_if.slave)
    );

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [P_W-1:0]  data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input int a, input int b);
        m_if.req_valid[i]         = v;
        m_if.req_a[i*A_W +: A_W]  = A_W'(a);
        m_if.req_b[i*B_W +: B_W]  = B_W'(b);
    endtask

    // One arbitration cycle: check the grant, optionally queue the expected product.
    task automatic cycle(input logic [3:0] exp_rdy, input bit push, input int id, input int data);
        @(negedge ap_clk);
        check("req_ready", 32'(m_if.req_ready), 32'(exp_rdy));
        if (push) sb.push_back(exp_t'{ID_W'(id), P_W'(data)});
        @(posedge ap_clk);
        #1;
    endtask

    task automatic drain();
        for (int c = 0; c < 30 && (sb.size() != 0 || m_if.busy !== 1'b0); c++) begin
            @(posedge ap_clk);
            #1;
        end
        check("drain_queue", 32'(sb.size()), 32'd0);
        check("drain_busy", 32'(m_if.busy), 32'd0);
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 0, 0);
`ifdef CNN_MUL_ARB_LOCK_EN
        m_if.req_lock = '0;
`endif
    endtask

    task automatic do_reset();
        clear_reqs();
        #2 ap_rst_n = 1'b0;
        sb.delete();
        @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
    endtask

    // Monitor: every accepted output beat must match the head of the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge ap_clk);
            if (ap_rst_n === 1'b1 && m_if.res_valid === 1'b1 && m_if.res_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result at %0t: got id=%0d data=%0d expected none",
                             $time, m_if.res_id, $signed(m_if.res_data));
                end else begin
                    e = sb.pop_front();
                    check("res_id", 32'(m_if.res_id), 32'(e.id));
                    check("res_data", 32'(m_if.res_data), 32'(e.data));
                    $display("result id=%0d data=%0d (expected id=%0d data=%0d)",
                             m_if.res_id, $signed(m_if.res_data), e.id, $signed(e.data));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        ap_rst_n       = 1'b0;
        m_if.req_valid = '0;
        m_if.req_a     = '0;
        m_if.req_b     = '0;
        m_if.res_ready = 1'b1;
`ifdef CNN_MUL_ARB_LOCK_EN
        m_if.req_lock  = '0;
`endif
        #3;
        check("rst_res_valid", 32'(m_if.res_valid), 32'd0);
        check("rst_res_data", 32'(m_if.res_data), 32'd0);
        check("rst_res_id", 32'(m_if.res_id), 32'd0);
        check("rst_busy", 32'(m_if.busy), 32'd0);
        check("rst_req_ready", 32'(m_if.req_ready), 32'd0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;

        // Single requester, largest positive corner product, latency check.
        set_req(1, 1'b1, -2048, -64);
        cycle(4'b0010, 1'b1, 1, 131072);
        set_req(1, 1'b0, 0, 0);
        @(negedge ap_clk);
        check("lat_valid_n1", 32'(m_if.res_valid), 32'd0);
        check("lat_busy_n1", 32'(m_if.busy), 32'd1);
        @(posedge ap_clk);
        #1;
        @(negedge ap_clk);
        check("lat_valid_n2", 32'(m_if.res_valid), 32'd1);
        @(posedge ap_clk);
        #1;
        drain();

        // All four valid: round-robin stream, then a 5-cycle backpressure stall.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, i + 1, 3);
        for (int k = 0; k < 8; k++) cycle(4'b0001 << (k % 4), 1'b1, k % 4, ((k % 4) + 1) * 3);
        m_if.res_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            @(negedge ap_clk);
            check("stall_req_ready", 32'(m_if.req_ready), 32'd0);
            check("stall_res_valid", 32'(m_if.res_valid), 32'd1);
            check("stall_res_data", 32'(m_if.res_data), 32'd9);
            check("stall_res_id", 32'(m_if.res_id), 32'd2);
            @(posedge ap_clk);
            #1;
        end
        m_if.res_ready = 1'b1;
        for (int k = 0; k < 4; k++) cycle(4'b0001 << k, 1'b1, k, (k + 1) * 3);
        clear_reqs();
        drain();

        // Requester 3 alone, most negative corner product (19'h60040).
        set_req(3, 1'b1, 2047, -64);
        cycle(4'b1000, 1'b1, 3, -131008);
        set_req(3, 1'b0, 0, 0);
        drain();

        // Asynchronous reset with two beats in flight; those beats must never appear.
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, i + 1, 3);
        cycle(4'b0001, 1'b0, 0, 0);
        cycle(4'b0010, 1'b0, 0, 0);
        check("pre_rst_busy", 32'(m_if.busy), 32'd1);
        check("pre_rst_valid", 32'(m_if.res_valid), 32'd1);
        #2 ap_rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(m_if.res_valid), 32'd0);
        check("async_rst_busy", 32'(m_if.busy), 32'd0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        check("post_rst_grant", 32'(m_if.req_ready), 32'd1);
        sb.push_back(exp_t'{ID_W'(0), P_W'(3)});
        @(posedge ap_clk);
        #1;
        clear_reqs();
        drain();

`ifdef CNN_MUL_ARB_LOCK_EN
        // Locked burst from requester 2, then round-robin resumes at 3.
        do_reset();
        set_req(2, 1'b1, 5, 2);
        m_if.req_lock[2] = 1'b1;
        cycle(4'b0100, 1'b1, 2, 10);
        set_req(0, 1'b1, 1, 3);
        set_req(1, 1'b1, 2, 3);
        set_req(3, 1'b1, 4, 3);
        set_req(2, 1'b1, 6, 2);
        cycle(4'b0100, 1'b1, 2, 12);
        set_req(2, 1'b1, 7, 2);
        m_if.req_lock[2] = 1'b0;
        cycle(4'b0100, 1'b1, 2, 14);
        set_req(2, 1'b0, 0, 0);
        cycle(4'b1000, 1'b1, 3, 12);
        cycle(4'b0001, 1'b1, 0, 3);
        cycle(4'b0010, 1'b1, 1, 6);
        clear_reqs();
        drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
